pipe_stage_reg: RTL and testbench

// Parametrised pipeline register for the multicycle/pipelined MIPS datapath,

---
 rtl/pipe_stage_reg.sv | 100 ++++++++++
 tb/tb_pipe_stage_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush for the MIPS datapath.
// SKID=1 gives a 2-entry skid buffer whose o_ready comes from state only.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      SKID      = 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_count
);

   logic             in_fire;
   logic             out_fire;
   logic [WIDTH-1:0] main_q;

   assign in_fire  = i_valid & o_ready;
   assign out_fire = o_valid & i_ready;
   assign o_data   = main_q;

   if (SKID != 0) begin : gen_skid
      typedef enum logic [1:0] {
         StEmpty = 2'd0,
         StBusy  = 2'd1,
         StFull  = 2'd2
      } state_e;

      state_e           state_q;
      logic [WIDTH-1:0] skid_q;

      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            state_q <= StEmpty;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
         end else if (i_flush) begin
            // Payload registers keep their contents; only occupancy is dropped.
            state_q <= StEmpty;
         end else begin
            case (state_q)
               StEmpty: begin
                  if (in_fire) begin
                     state_q <= StBusy;
                     main_q  <= i_data;
                  end
               end
               StBusy: begin
                  if (in_fire && out_fire) begin
                     main_q <= i_data;
                  end else if (in_fire) begin
                     state_q <= StFull;
                     skid_q  <= i_data;
                  end else if (out_fire) begin
                     state_q <= StEmpty;
                  end
               end
               StFull: begin
                  if (out_fire) begin
                     state_q <= StBusy;
                     main_q  <= skid_q;
                  end
               end
               default: state_q <= StEmpty;
            endcase
         end
      end

      assign o_valid = (state_q != StEmpty);
      assign o_ready = (state_q != StFull);
      assign o_count = 2'(state_q);
   end else begin : gen_single
      logic valid_q;

      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            valid_q <= 1'b0;
            main_q  <= RESET_VAL;
         end else if (i_flush) begin
            valid_q <= 1'b0;
         end else if (in_fire) begin
            valid_q <= 1'b1;
            main_q  <= i_data;
         end else if (out_fire) begin
            valid_q <= 1'b0;
         end
      end

      assign o_valid = valid_q;
      assign o_ready = ~valid_q | i_ready;
      assign o_count = {1'b0, valid_q};
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector tables for both SKID modes, then a randomised run of both
// instances against a queue-based reference model.
module tb_pipe_stage_reg;

   localparam logic [31:0] RV1 = 32'hA5A5_0001;
   localparam logic [31:0] RV0 = 32'h0000_5A5A;

   typedef struct {
      logic        rst;
      logic        fl;
      logic        v;
      logic [31:0] d;
      logic        r;
      logic        e_rdy;
      logic        e_v;
      logic [31:0] e_d;
      logic [1:0]  e_c;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_fl, a_v, a_r, a_o_rdy, a_o_v;
   logic [31:0] a_d, a_o_d;
   logic [1:0]  a_o_c;
   logic        b_fl, b_v, b_r, b_o_rdy, b_o_v;
   logic [31:0] b_d, b_o_d;
   logic [1:0]  b_o_c;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV1), .SKID(1)) dut_skid (
      .i_clk   (clk),
      .i_reset (rst),
      .i_flush (a_fl),
      .i_valid (a_v),
      .o_ready (a_o_rdy),
      .i_data  (a_d),
      .o_valid (a_o_v),
      .i_ready (a_r),
      .o_data  (a_o_d),
      .o_count (a_o_c)
   );

   pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV0), .SKID(0)) dut_single (
      .i_clk   (clk),
      .i_reset (rst),
      .i_flush (b_fl),
      .i_valid (b_v),
      .o_ready (b_o_rdy),
      .i_data  (b_d),
      .o_valid (b_o_v),
      .i_ready (b_r),
      .o_data  (b_o_d),
      .o_count (b_o_c)
   );

   function automatic vec_t mk(logic rst_v, logic fl, logic v, logic [31:0] d, logic r,
                               logic e_rdy, logic e_v, logic [31:0] e_d, logic [1:0] e_c);
      vec_t t;
      t.rst = rst_v; t.fl = fl; t.v = v; t.d = d; t.r = r;
      t.e_rdy = e_rdy; t.e_v = e_v; t.e_d = e_d; t.e_c = e_c;
      return t;
   endfunction

   // SKID=1: every output is registered, so all fields are checked after the edge.
   task automatic run_skid(input vec_t t, input int idx);
      @(negedge clk);
      rst = t.rst; a_fl = t.fl; a_v = t.v; a_d = t.d; a_r = t.r;
      @(posedge clk);
      #1;
      n_vec++;
      if (a_o_rdy !== t.e_rdy || a_o_v !== t.e_v || a_o_d !== t.e_d || a_o_c !== t.e_c) begin
         n_miss++;
         $display("FAIL skid1_vec%0d: got rdy=%b v=%b d=%h c=%0d, want rdy=%b v=%b d=%h c=%0d",
                  idx, a_o_rdy, a_o_v, a_o_d, a_o_c, t.e_rdy, t.e_v, t.e_d, t.e_c);
      end
   endtask

   // SKID=0: o_ready is combinational, so it is checked before the edge.
   task automatic run_single(input vec_t t, input int idx);
      logic rdy_pre;
      @(negedge clk);
      rst = t.rst; b_fl = t.fl; b_v = t.v; b_d = t.d; b_r = t.r;
      #1;
      rdy_pre = b_o_rdy;
      @(posedge clk);
      #1;
      n_vec++;
      if (rdy_pre !== t.e_rdy || b_o_v !== t.e_v || b_o_d !== t.e_d || b_o_c !== t.e_c) begin
         n_miss++;
         $display("FAIL skid0_vec%0d: got rdy=%b v=%b d=%h c=%0d, want rdy=%b v=%b d=%h c=%0d",
                  idx, rdy_pre, b_o_v, b_o_d, b_o_c, t.e_rdy, t.e_v, t.e_d, t.e_c);
      end
   endtask

   vec_t        tab1[$];
   vec_t        tab0[$];
   logic [31:0] q1[$];
   logic [31:0] q0[$];
   logic [31:0] m1_main, m0_main;
   logic        e_rdy, e_v;

   initial begin
      rst = 1'b1;
      a_fl = 1'b0; a_v = 1'b0; a_d = '0; a_r = 1'b0;
      b_fl = 1'b0; b_v = 1'b0; b_d = '0; b_r = 1'b0;

      //             rst fl v  d             r   rdy v  d    c
      tab1.push_back(mk(1, 0, 1, 32'hDEAD_BEEF, 1, 1, 0, RV1, 2'd0));
      tab1.push_back(mk(0, 0, 1, 1,  1, 1, 1, 1,  2'd1));
      tab1.push_back(mk(0, 0, 1, 2,  1, 1, 1, 2,  2'd1));
      tab1.push_back(mk(0, 0, 1, 3,  1, 1, 1, 3,  2'd1));
      tab1.push_back(mk(0, 0, 1, 4,  1, 1, 1, 4,  2'd1));
      tab1.push_back(mk(0, 0, 0, 0,  1, 1, 0, 4,  2'd0));
      tab1.push_back(mk(0, 0, 1, 10, 0, 1, 1, 10, 2'd1));
      tab1.push_back(mk(0, 0, 1, 11, 0, 0, 1, 10, 2'd2));
      tab1.push_back(mk(0, 0, 1, 12, 0, 0, 1, 10, 2'd2));
      tab1.push_back(mk(0, 0, 1, 12, 1, 1, 1, 11, 2'd1));
      tab1.push_back(mk(0, 0, 1, 12, 1, 1, 1, 12, 2'd1));
      tab1.push_back(mk(0, 0, 0, 0,  1, 1, 0, 12, 2'd0));
      tab1.push_back(mk(0, 0, 1, 20, 0, 1, 1, 20, 2'd1));
      tab1.push_back(mk(0, 0, 1, 21, 0, 0, 1, 20, 2'd2));
      tab1.push_back(mk(0, 1, 1, 22, 0, 1, 0, 20, 2'd0));
      tab1.push_back(mk(0, 0, 0, 0,  1, 1, 0, 20, 2'd0));
      tab1.push_back(mk(0, 1, 1, 30, 1, 1, 0, 20, 2'd0));
      tab1.push_back(mk(0, 0, 1, 31, 0, 1, 1, 31, 2'd1));
      tab1.push_back(mk(0, 1, 1, 32, 0, 1, 0, 31, 2'd0));
      tab1.push_back(mk(0, 0, 1, 50, 0, 1, 1, 50, 2'd1));
      tab1.push_back(mk(0, 0, 0, 0,  0, 1, 1, 50, 2'd1));
      tab1.push_back(mk(0, 0, 1, 40, 0, 0, 1, 50, 2'd2));
      tab1.push_back(mk(1, 1, 1, 41, 1, 1, 0, RV1, 2'd0));

      tab0.push_back(mk(1, 0, 1, 32'hDEAD_BEEF, 1, 1, 0, RV0, 2'd0));
      tab0.push_back(mk(0, 0, 1, 5,  0, 1, 1, 5,  2'd1));
      tab0.push_back(mk(0, 0, 1, 6,  0, 0, 1, 5,  2'd1));
      tab0.push_back(mk(0, 0, 1, 7,  1, 1, 1, 7,  2'd1));
      tab0.push_back(mk(0, 0, 0, 0,  1, 1, 0, 7,  2'd0));
      tab0.push_back(mk(0, 0, 0, 0,  0, 1, 0, 7,  2'd0));
      tab0.push_back(mk(0, 0, 1, 8,  0, 1, 1, 8,  2'd1));
      tab0.push_back(mk(0, 1, 1, 9,  1, 1, 0, 8,  2'd0));
      tab0.push_back(mk(0, 1, 1, 10, 0, 1, 0, 8,  2'd0));
      tab0.push_back(mk(0, 0, 1, 11, 1, 1, 1, 11, 2'd1));
      tab0.push_back(mk(1, 1, 1, 12, 0, 0, 0, RV0, 2'd0));

      repeat (2) @(posedge clk);

      foreach (tab1[i]) run_skid(tab1[i], i);
      @(negedge clk);
      a_v = 1'b0; a_fl = 1'b0; rst = 1'b0;
      foreach (tab0[i]) run_single(tab0[i], i);

      // Random run: both instances driven independently, each against its model.
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      m1_main = RV1;
      m0_main = RV0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         rst  = 1'b0;
         a_fl = ($urandom_range(99) == 0);
         a_v  = $urandom_range(1);
         a_d  = $urandom;
         a_r  = $urandom_range(1);
         b_fl = ($urandom_range(99) == 0);
         b_v  = $urandom_range(1);
         b_d  = $urandom;
         b_r  = $urandom_range(1);
         #1;

         e_rdy = (q1.size() < 2);
         e_v   = (q1.size() != 0);
         n_vec++;
         if (a_o_rdy !== e_rdy || a_o_v !== e_v || a_o_d !== m1_main ||
             a_o_c !== 2'(q1.size())) begin
            n_miss++;
            $display("FAIL rand_skid1 cyc%0d: got rdy=%b v=%b d=%h c=%0d, want rdy=%b v=%b d=%h c=%0d",
                     i, a_o_rdy, a_o_v, a_o_d, a_o_c, e_rdy, e_v, m1_main, q1.size());
         end
         if (a_fl) begin
            q1.delete();
         end else begin
            if (e_v && a_r) void'(q1.pop_front());
            if (a_v && e_rdy) q1.push_back(a_d);
         end
         if (q1.size() != 0) m1_main = q1[0];

         e_rdy = (q0.size() == 0) || b_r;
         e_v   = (q0.size() != 0);
         n_vec++;
         if (b_o_rdy !== e_rdy || b_o_v !== e_v || b_o_d !== m0_main ||
             b_o_c !== 2'(q0.size())) begin
            n_miss++;
            $display("FAIL rand_skid0 cyc%0d: got rdy=%b v=%b d=%h c=%0d, want rdy=%b v=%b d=%h c=%0d",
                     i, b_o_rdy, b_o_v, b_o_d, b_o_c, e_rdy, e_v, m0_main, q0.size());
         end
         if (b_fl) begin
            q0.delete();
         end else begin
            if (e_v && b_r) void'(q0.pop_front());
            if (b_v && e_rdy) q0.push_back(b_d);
         end
         if (q0.size() != 0) m0_main = q0[0];
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
